// File: rtl/ch4_ctrl.sv
// ch4_ctrl: register and sequencing controller for the noise channel.
// Owns NR41..NR44 state, the restart pulse, the 64-step length counter
// and the channel's active / DAC-enable status.
module ch4_ctrl #(
  parameter int unsigned RESTART_CYCLES = 4  // legal range 1..15
) (
  input  logic       dova_phi,
  input  logic       napu_reset,
  input  logic       apu_en,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       ff20,
  input  logic       ff21,
  input  logic       ff22,
  input  logic       ff23,
  input  logic [7:0] d_in,
  input  logic       len_tick,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic [7:0] ff21_q,
  output logic [7:0] ff22_q,
  output logic       ff23_d6,
  output logic       ch4_restart,
  output logic       ch4_active,
  output logic       dac_en
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RESTART = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // rs_cnt counts down the remaining pulse cycles after the first one.
  localparam logic [3:0] RS_LOAD = 4'(RESTART_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_rs_cnt;
  logic       r_restart;
  logic       r_active;
  logic [7:0] r_ff21_q;
  logic [7:0] r_ff22_q;
  logic       r_ff23_d6;
  logic [6:0] r_len_cnt;

  logic       w_trigger;
  logic       w_ff20_wr;
  logic       w_dac_en;
  logic       w_len_zero;
  logic       w_any_sel;

  assign w_trigger  = apu_en & cpu_wr & ff23 & d_in[7];
  assign w_ff20_wr  = cpu_wr & ff20;
  assign w_dac_en   = |r_ff21_q[7:3];
  assign w_len_zero = (r_len_cnt == 7'd0);
  assign w_any_sel  = ff20 | ff21 | ff22 | ff23;

  assign ff21_q      = r_ff21_q;
  assign ff22_q      = r_ff22_q;
  assign ff23_d6     = r_ff23_d6;
  assign ch4_restart = r_restart;
  assign ch4_active  = r_active;
  assign dac_en      = w_dac_en;

  // NR42 / NR43 / NR44 length-enable registers; cleared while the APU is off.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge dova_phi or negedge napu_reset) begin
    if (!napu_reset) begin
      r_ff21_q  <= '0;
      r_ff22_q  <= '0;
      r_ff23_d6 <= 1'b0;
    end else if (!apu_en) begin
      r_ff21_q  <= '0;
      r_ff22_q  <= '0;
      r_ff23_d6 <= 1'b0;
    end else if (cpu_wr) begin
      if (ff21) r_ff21_q  <= d_in;
      if (ff22) r_ff22_q  <= d_in;
      if (ff23) r_ff23_d6 <= d_in[6];
    end
  end

  // Length counter: FF20 load beats everything, trigger reload beats ticks.
  always_ff @(posedge dova_phi or negedge napu_reset) begin
    if (!napu_reset) begin
      r_len_cnt <= '0;
    end else if (w_ff20_wr) begin
      r_len_cnt <= 7'd64 - {1'b0, d_in[5:0]};
    end else if (apu_en) begin
      if (w_trigger) begin
        if (w_len_zero) r_len_cnt <= 7'd64;
      end else if (len_tick && r_ff23_d6 && !w_len_zero) begin
        r_len_cnt <= r_len_cnt - 7'd1;
      end
    end
  end

  // Channel sequencer: OFF -> RESTART (pulse) -> RUN, with registered outputs.
  always_ff @(posedge dova_phi or negedge napu_reset) begin
    if (!napu_reset) begin
      r_state   <= ST_OFF;
      r_rs_cnt  <= '0;
      r_restart <= 1'b0;
      r_active  <= 1'b0;
    end else if (!apu_en) begin
      r_state   <= ST_OFF;
      r_rs_cnt  <= '0;
      r_restart <= 1'b0;
      r_active  <= 1'b0;
    end else if (w_trigger) begin
      // A retrigger inside RESTART just reloads the counter, stretching the pulse.
      r_state   <= ST_RESTART;
      r_rs_cnt  <= RS_LOAD;
      r_restart <= 1'b1;
      r_active  <= w_dac_en;
    end else begin
      unique case (r_state)
        ST_RESTART: begin
          r_active <= w_dac_en;
          if (r_rs_cnt == 4'd0) begin
            r_restart <= 1'b0;
            r_state   <= w_dac_en ? ST_RUN : ST_OFF;
          end else begin
            r_rs_cnt <= r_rs_cnt - 4'd1;
          end
        end
        ST_RUN: begin
          if (!w_dac_en || w_len_zero) begin
            r_state  <= ST_OFF;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_OFF;
          r_restart <= 1'b0;
          r_active  <= 1'b0;
        end
      endcase
    end
  end

  // CPU read mux; unimplemented bits read back as 1.
  // NOTE: d_out gets a default before the selects so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    d_out = 8'hFF;
    if (ff21)      d_out = r_ff21_q;
    else if (ff22) d_out = r_ff22_q;
    else if (ff23) d_out = {1'b1, r_ff23_d6, 6'b111111};
    d_oe = cpu_rd & w_any_sel;
  end

endmodule

// File: tb/tb_ch4_ctrl.sv
// tb_ch4_ctrl: scoreboard bench for ch4_ctrl. The driver steps a behavioural
// model on every clock edge and queues the expected outputs; a monitor pops
// and compares on the falling edge.
module tb_ch4_ctrl;

  localparam int RC = 4;

  logic       dova_phi;
  logic       napu_reset;
  logic       apu_en;
  logic       cpu_wr;
  logic       cpu_rd;
  logic       ff20;
  logic       ff21;
  logic       ff22;
  logic       ff23;
  logic [7:0] d_in;
  logic       len_tick;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] ff21_q;
  logic [7:0] ff22_q;
  logic       ff23_d6;
  logic       ch4_restart;
  logic       ch4_active;
  logic       dac_en;

  ch4_ctrl #(.RESTART_CYCLES(RC)) dut (
    .dova_phi    (dova_phi),
    .napu_reset  (napu_reset),
    .apu_en      (apu_en),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .ff20        (ff20),
    .ff21        (ff21),
    .ff22        (ff22),
    .ff23        (ff23),
    .d_in        (d_in),
    .len_tick    (len_tick),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .ff21_q      (ff21_q),
    .ff22_q      (ff22_q),
    .ff23_d6     (ff23_d6),
    .ch4_restart (ch4_restart),
    .ch4_active  (ch4_active),
    .dac_en      (dac_en)
  );

  initial dova_phi = 1'b0;
  always #5 dova_phi = ~dova_phi;

  typedef struct {
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] ff21;
    logic [7:0] ff22;
    logic       d6;
    logic       restart;
    logic       active;
    logic       dac;
    logic [6:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: register contents, remaining pulse cycles, running flag.
  logic [7:0] m_ff21;
  logic [7:0] m_ff22;
  logic       m_d6;
  int         m_len;
  int         m_pulse_left;
  bit         m_running;
  bit         m_active;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ff21 = '0; m_ff22 = '0; m_d6 = 1'b0; m_len = 0;
    m_pulse_left = 0; m_running = 1'b0; m_active = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit trig;
    bit dac;
    int nlen;
    trig = apu_en && cpu_wr && ff23 && d_in[7];
    dac  = (m_ff21[7:3] != 5'd0);
    nlen = m_len;
    if (cpu_wr && ff20) nlen = 64 - int'(d_in[5:0]);
    else if (apu_en) begin
      if (trig) begin
        if (m_len == 0) nlen = 64;
      end else if (len_tick && m_d6 && m_len > 0) nlen = m_len - 1;
    end
    if (!apu_en) begin
      m_pulse_left = 0; m_running = 1'b0; m_active = 1'b0;
    end else if (trig) begin
      m_pulse_left = RC; m_running = 1'b0; m_active = dac;
    end else if (m_pulse_left > 0) begin
      m_pulse_left--;
      if (m_pulse_left == 0) m_running = dac;
      m_active = dac;
    end else if (m_running) begin
      if (!dac || m_len == 0) m_running = 1'b0;
      m_active = m_running;
    end else begin
      m_active = 1'b0;
    end
    if (!apu_en) begin
      m_ff21 = '0; m_ff22 = '0; m_d6 = 1'b0;
    end else if (cpu_wr) begin
      if (ff21) m_ff21 = d_in;
      if (ff22) m_ff22 = d_in;
      if (ff23) m_d6 = d_in[6];
    end
    m_len = nlen;
  endtask

  task automatic push_exp();
    exp_t e;
    e.d_oe = cpu_rd && (ff20 || ff21 || ff22 || ff23);
    if (ff20)      e.d_out = 8'hFF;
    else if (ff21) e.d_out = m_ff21;
    else if (ff22) e.d_out = m_ff22;
    else if (ff23) e.d_out = {1'b1, m_d6, 6'h3F};
    else           e.d_out = 8'hFF;
    e.ff21    = m_ff21;
    e.ff22    = m_ff22;
    e.d6      = m_d6;
    e.restart = (m_pulse_left > 0);
    e.active  = m_active;
    e.dac     = (m_ff21[7:3] != 5'd0);
    e.len     = 7'(m_len);
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus; sel is {ff23, ff22, ff21, ff20}.
  task automatic drive(input bit apu, input bit wr, input bit rd,
                       input logic [3:0] sel, input logic [7:0] d, input bit tick);
    @(posedge dova_phi);
    model_edge();
    #1;
    apu_en = apu; cpu_wr = wr; cpu_rd = rd;
    {ff23, ff22, ff21, ff20} = sel;
    d_in = d; len_tick = tick;
    push_exp();
  endtask

  task automatic wr_reg(input logic [3:0] sel, input logic [7:0] d);
    drive(1'b1, 1'b1, 1'b0, sel, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0);
  endtask

  task automatic tick();
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b1);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge dova_phi);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("d_out",       d_out,       e.d_out);
        check("d_oe",        d_oe,        e.d_oe);
        check("ff21_q",      ff21_q,      e.ff21);
        check("ff22_q",      ff22_q,      e.ff22);
        check("ff23_d6",     ff23_d6,     e.d6);
        check("ch4_restart", ch4_restart, e.restart);
        check("ch4_active",  ch4_active,  e.active);
        check("dac_en",      dac_en,      e.dac);
        check("len_cnt",     dut.r_len_cnt, e.len);
      end
    end
  end

  initial begin
    napu_reset = 1'b0;
    apu_en = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0;
    ff20 = 1'b0; ff21 = 1'b0; ff22 = 1'b0; ff23 = 1'b0;
    d_in = 8'h00; len_tick = 1'b0;
    model_reset();
    #3;
    push_exp();              // reset state, compared at the first falling edge
    #9;
    napu_reset = 1'b1;

    // Reads after reset: FF20..FF23 -> FF, 00, 00, BF.
    drive(1'b1, 1'b0, 1'b1, 4'b0001, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b0010, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b0100, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b1000, 8'h00, 1'b0);
    idle(1);

    // Basic trigger with DAC on: 4-cycle pulse, active from +1, len -> 64.
    wr_reg(4'b0010, 8'hF0);
    wr_reg(4'b1000, 8'h80);
    idle(7);

    // Length expiry: len 2 -> 1 -> 0, then a third tick stays at 0.
    wr_reg(4'b0001, 8'h3E);
    wr_reg(4'b0010, 8'h10);
    wr_reg(4'b1000, 8'hC0);
    idle(6);
    tick(); idle(1);
    tick(); idle(2);
    tick(); idle(2);

    // Trigger with DAC off: pulse runs, active stays low, ends OFF.
    wr_reg(4'b0010, 8'h07);
    wr_reg(4'b1000, 8'h80);
    idle(7);

    // APU off while running: writes ignored except FF20, ticks ignored.
    wr_reg(4'b0010, 8'hF0);
    wr_reg(4'b1000, 8'h80);
    idle(6);
    drive(1'b0, 1'b1, 1'b0, 4'b0010, 8'hFF, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'b0010, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 8'h10, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0);
    idle(2);

    // Trigger coincident with a tick at len 0, then a retrigger 2 cycles on.
    wr_reg(4'b0010, 8'hF0);
    wr_reg(4'b0001, 8'h3F);
    wr_reg(4'b1000, 8'hC0);
    idle(6);
    tick(); idle(2);
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 8'hC0, 1'b1);
    idle(1);
    wr_reg(4'b1000, 8'hC0);
    idle(8);

    // FF23 write enabling length with a coincident tick uses the old enable;
    // FF20 write with a coincident tick keeps the written value.
    wr_reg(4'b1000, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 8'h40, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'b0001, 8'h20, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         apu;
      bit         wr;
      bit         rd;
      int         r;
      logic [3:0] sel;
      logic [7:0] d;
      apu = ($urandom_range(0, 39) != 0);
      wr  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 1) == 0);
      r   = $urandom_range(0, 4);
      sel = (r == 4) ? 4'b0000 : 4'(1 << r);
      d   = 8'($urandom);
      drive(apu, wr, rd, sel, d, ($urandom_range(0, 5) == 0));
    end
    idle(2);

    // Asynchronous reset in the middle of a pulse drops ch4_restart at once.
    wr_reg(4'b0010, 8'hF0);
    wr_reg(4'b1000, 8'h80);
    idle(1);
    #6;
    check("restart_before_reset", ch4_restart, 1'b1);
    napu_reset = 1'b0;
    #1;
    check("restart_async_reset", ch4_restart, 1'b0);
    check("active_async_reset",  ch4_active,  1'b0);
    #20;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
